// File: rtl/rv32_ctrl_pkg.sv
// Opcodes, ALU/immediate encodings and the ID/EX control bundle shared by the RV32IM control unit.
package rv32_ctrl_pkg;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;
   localparam logic [6:0] F7_MEXT = 7'b0000001;

   typedef enum logic [4:0] {
      ALU_ADD    = 5'b00000,
      ALU_SUB    = 5'b00001,
      ALU_SLL    = 5'b00010,
      ALU_SLT    = 5'b00011,
      ALU_SLTU   = 5'b00100,
      ALU_XOR    = 5'b00101,
      ALU_SRL    = 5'b00110,
      ALU_SRA    = 5'b00111,
      ALU_OR     = 5'b01000,
      ALU_AND    = 5'b01001,
      ALU_MUL    = 5'b01010,
      ALU_MULH   = 5'b01011,
      ALU_MULHSU = 5'b01100,
      ALU_MULHU  = 5'b01101,
      ALU_DIV    = 5'b01110,
      ALU_DIVU   = 5'b01111,
      ALU_REM    = 5'b10000,
      ALU_REMU   = 5'b10001,
      ALU_FWD    = 5'b10010
   } alu_op_e;

   typedef enum logic [2:0] {
      IMM_I    = 3'b000,
      IMM_S    = 3'b001,
      IMM_B    = 3'b010,
      IMM_U    = 3'b011,
      IMM_J    = 3'b100,
      IMM_NONE = 3'b111
   } imm_type_e;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_MWAIT = 1'b1
   } state_e;

   typedef struct packed {
      alu_op_e    alu_op;
      imm_type_e  imm_type;
      logic       write_enable;
      logic       memory_access;
      logic       mem_write;
      logic       mem_read;
      logic       jump_and_link;
      logic       immediate_select;
      logic       offset_generator;
      logic       branch;
      logic       jump;
      logic [2:0] funct3;
      logic [4:0] rd_addr;
   } ctrl_t;

   function automatic ctrl_t ctrl_nop();
      ctrl_t c;
      c          = '0;
      c.imm_type = IMM_NONE;
      return c;
   endfunction

   // funct3 -> ALU op for the base-encoded (funct7 = 0) register and immediate forms.
   function automatic alu_op_e alu_base(input logic [2:0] f3);
      case (f3)
         3'd0:    return ALU_ADD;
         3'd1:    return ALU_SLL;
         3'd2:    return ALU_SLT;
         3'd3:    return ALU_SLTU;
         3'd4:    return ALU_XOR;
         3'd5:    return ALU_SRL;
         3'd6:    return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction

endpackage

// File: rtl/rv32_decode_comb.sv
// Pure combinational RV32IM decode: control bundle, EX cycle count and illegal flag.
module rv32_decode_comb
   import rv32_ctrl_pkg::*;
#(
   parameter int M_EXT      = 1,
   parameter int MUL_CYCLES = 1,
   parameter int DIV_CYCLES = 4,
   parameter int CNT_W      = 6
) (
   input  logic [31:0]      instruction,
   output ctrl_t            ctrl,
   output logic [CNT_W-1:0] op_cycles,
   output logic             illegal
);

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic       unused_fields;

   assign opcode        = instruction[6:0];
   assign funct3        = instruction[14:12];
   assign funct7        = instruction[31:25];
   assign unused_fields = ^instruction[24:15];

   always_comb begin
      ctrl           = ctrl_nop();
      ctrl.funct3    = funct3;
      ctrl.rd_addr   = instruction[11:7];
      op_cycles      = CNT_W'(1);
      illegal        = 1'b0;

      case (opcode)
         OP_R: begin
            ctrl.write_enable = 1'b1;
            case (funct7)
               F7_BASE: ctrl.alu_op = alu_base(funct3);
               F7_ALT: begin
                  if (funct3 == 3'd0)      ctrl.alu_op = ALU_SUB;
                  else if (funct3 == 3'd5) ctrl.alu_op = ALU_SRA;
                  else                     illegal     = 1'b1;
               end
               F7_MEXT: begin
                  if (M_EXT == 0) begin
                     illegal = 1'b1;
                  end else begin
                     case (funct3)
                        3'd0:    ctrl.alu_op = ALU_MUL;
                        3'd1:    ctrl.alu_op = ALU_MULH;
                        3'd2:    ctrl.alu_op = ALU_MULHSU;
                        3'd3:    ctrl.alu_op = ALU_MULHU;
                        3'd4:    ctrl.alu_op = ALU_DIV;
                        3'd5:    ctrl.alu_op = ALU_DIVU;
                        3'd6:    ctrl.alu_op = ALU_REM;
                        default: ctrl.alu_op = ALU_REMU;
                     endcase
                     // funct3[2] splits the multiplier group from divide/remainder.
                     op_cycles = funct3[2] ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
                  end
               end
               default: illegal = 1'b1;
            endcase
         end
         OP_IMM: begin
            ctrl.immediate_select = 1'b1;
            ctrl.imm_type         = IMM_I;
            ctrl.alu_op           = alu_base(funct3);
            if (funct3 == 3'd1 && funct7 != F7_BASE) illegal = 1'b1;
            if (funct3 == 3'd5) begin
               if (funct7 == F7_ALT)        ctrl.alu_op = ALU_SRA;
               else if (funct7 != F7_BASE)  illegal     = 1'b1;
            end
         end
         OP_LOAD: begin
            ctrl.memory_access = 1'b1;
            ctrl.mem_read      = 1'b1;
            ctrl.write_enable  = 1'b1;
            ctrl.imm_type      = IMM_I;
            if (funct3 == 3'd3 || funct3 == 3'd6 || funct3 == 3'd7) illegal = 1'b1;
         end
         OP_STORE: begin
            ctrl.memory_access = 1'b1;
            ctrl.mem_write     = 1'b1;
            ctrl.imm_type      = IMM_S;
            if (funct3 > 3'd2) illegal = 1'b1;
         end
         OP_BRANCH: begin
            ctrl.branch           = 1'b1;
            ctrl.offset_generator = 1'b1;
            ctrl.alu_op           = ALU_SUB;
            ctrl.imm_type         = IMM_B;
            if (funct3 == 3'd2 || funct3 == 3'd3) illegal = 1'b1;
         end
         OP_JAL: begin
            ctrl.jump             = 1'b1;
            ctrl.jump_and_link    = 1'b1;
            ctrl.offset_generator = 1'b1;
            ctrl.imm_type         = IMM_J;
         end
         OP_JALR: begin
            ctrl.jump             = 1'b1;
            ctrl.jump_and_link    = 1'b1;
            ctrl.immediate_select = 1'b1;
            ctrl.imm_type         = IMM_I;
            if (funct3 != 3'd0) illegal = 1'b1;
         end
         OP_LUI: begin
            ctrl.alu_op   = ALU_FWD;
            ctrl.imm_type = IMM_U;
         end
         OP_AUIPC: begin
            ctrl.offset_generator = 1'b1;
            ctrl.imm_type         = IMM_U;
         end
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/pipelined_control_unit.sv
// Registered ID/EX control stage: one-cycle decode latency, stalls the front end for multi-cycle M ops.
module pipelined_control_unit
   import rv32_ctrl_pkg::*;
#(
   parameter int M_EXT      = 1,
   parameter int MUL_CYCLES = 1,
   parameter int DIV_CYCLES = 4,
   parameter int CNT_W      = 6
) (
   input  logic        CLK,
   input  logic        RESET_N,
   input  logic [31:0] INSTRUCTION,
   input  logic        ID_VALID,
   input  logic        HOLD,
   input  logic        FLUSH,
   output logic [4:0]  ALU_OPCODE,
   output logic [2:0]  IMMEDIATE_TYPE,
   output logic        WRITE_ENABLE,
   output logic        MEMORY_ACCESS,
   output logic        MEM_WRITE,
   output logic        MEM_READ,
   output logic        JUMP_AND_LINK,
   output logic        IMMEDIATE_SELECT,
   output logic        OFFSET_GENARATOR,
   output logic        BRANCH,
   output logic        JUMP,
   output logic [2:0]  FUNCT3,
   output logic [4:0]  RD_ADDR,
   output logic        EX_VALID,
   output logic        ILLEGAL,
   output logic        STALL_ID
);

   ctrl_t            dec_ctrl;
   logic [CNT_W-1:0] dec_cycles;
   logic             dec_illegal;
   logic             dec_multi;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   ctrl_t            ctrl_q, load_ctrl;
   logic             ex_valid_q, illegal_q;
   logic             load_en, load_vld, load_ill;

   rv32_decode_comb #(
      .M_EXT      (M_EXT),
      .MUL_CYCLES (MUL_CYCLES),
      .DIV_CYCLES (DIV_CYCLES),
      .CNT_W      (CNT_W)
   ) u_decode (
      .instruction (INSTRUCTION),
      .ctrl        (dec_ctrl),
      .op_cycles   (dec_cycles),
      .illegal     (dec_illegal)
   );

   assign dec_multi = ID_VALID && !dec_illegal && (dec_cycles > CNT_W'(1));

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q <= ST_RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Every non-held edge reloads ID/EX; anything but a live legal op in RUN loads a bubble.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      load_en   = 1'b0;
      load_ctrl = ctrl_nop();
      load_vld  = 1'b0;
      load_ill  = 1'b0;
      if (FLUSH) begin
         state_d = ST_RUN;
         cnt_d   = '0;
         load_en = 1'b1;
      end else if (!HOLD) begin
         load_en = 1'b1;
         case (state_q)
            ST_RUN: begin
               if (ID_VALID && dec_illegal) begin
                  load_ill = 1'b1;
               end else if (ID_VALID) begin
                  load_ctrl = dec_ctrl;
                  load_vld  = 1'b1;
                  if (dec_multi) begin
                     state_d = ST_MWAIT;
                     cnt_d   = dec_cycles - CNT_W'(1);
                  end
               end
            end
            default: begin
               cnt_d = cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) state_d = ST_RUN;
            end
         endcase
      end
   end

   always_comb begin
      STALL_ID = (state_q == ST_MWAIT) || ((state_q == ST_RUN) && dec_multi);
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         ctrl_q     <= ctrl_nop();
         ex_valid_q <= 1'b0;
         illegal_q  <= 1'b0;
      end else if (load_en) begin
         ctrl_q     <= load_ctrl;
         ex_valid_q <= load_vld;
         illegal_q  <= load_ill;
      end
   end

   assign ALU_OPCODE       = ctrl_q.alu_op;
   assign IMMEDIATE_TYPE   = ctrl_q.imm_type;
   assign WRITE_ENABLE     = ctrl_q.write_enable;
   assign MEMORY_ACCESS    = ctrl_q.memory_access;
   assign MEM_WRITE        = ctrl_q.mem_write;
   assign MEM_READ         = ctrl_q.mem_read;
   assign JUMP_AND_LINK    = ctrl_q.jump_and_link;
   assign IMMEDIATE_SELECT = ctrl_q.immediate_select;
   assign OFFSET_GENARATOR = ctrl_q.offset_generator;
   assign BRANCH           = ctrl_q.branch;
   assign JUMP             = ctrl_q.jump;
   assign FUNCT3           = ctrl_q.funct3;
   assign RD_ADDR          = ctrl_q.rd_addr;
   assign EX_VALID         = ex_valid_q;
   assign ILLEGAL          = illegal_q;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Two parameterisations (M_EXT=1 MUL=3 DIV=4, M_EXT=0) driven identically and scored against one reference model.
module tb_pipelined_control_unit;

   localparam logic [26:0] NOP_VEC = {5'd0, 3'b111, 19'd0};
   localparam logic [31:0] I_ADD   = 32'h001101B3;
   localparam logic [31:0] I_LW    = 32'h00112183;
   localparam logic [31:0] I_BEQ   = 32'h00110063;
   localparam logic [31:0] I_DIV   = 32'h021141B3;
   localparam logic [31:0] I_ADDI  = 32'h00000013;

   logic        CLK = 1'b0;
   logic        RESET_N = 1'b0;
   logic [31:0] INSTRUCTION = '0;
   logic        ID_VALID = 1'b0;
   logic        HOLD = 1'b0;
   logic        FLUSH = 1'b0;

   logic [27:0] obs [2];
   logic [26:0] m_reg [2];
   int          m_wait [2];
   int          n_checks = 0;
   int          n_fail = 0;
   int          stall_cnt = 0;

   always #5 CLK = ~CLK;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      logic [4:0] alu, rd;
      logic [2:0] imm, f3;
      logic we, ma, mw, mr, jal, isel, og, br, jmp, exv, ill, stall;
      pipelined_control_unit #(
         .M_EXT      (g == 0 ? 1 : 0),
         .MUL_CYCLES (g == 0 ? 3 : 1),
         .DIV_CYCLES (4),
         .CNT_W      (6)
      ) u_dut (
         .CLK              (CLK),
         .RESET_N          (RESET_N),
         .INSTRUCTION      (INSTRUCTION),
         .ID_VALID         (ID_VALID),
         .HOLD             (HOLD),
         .FLUSH            (FLUSH),
         .ALU_OPCODE       (alu),
         .IMMEDIATE_TYPE   (imm),
         .WRITE_ENABLE     (we),
         .MEMORY_ACCESS    (ma),
         .MEM_WRITE        (mw),
         .MEM_READ         (mr),
         .JUMP_AND_LINK    (jal),
         .IMMEDIATE_SELECT (isel),
         .OFFSET_GENARATOR (og),
         .BRANCH           (br),
         .JUMP             (jmp),
         .FUNCT3           (f3),
         .RD_ADDR          (rd),
         .EX_VALID         (exv),
         .ILLEGAL          (ill),
         .STALL_ID         (stall)
      );
      assign obs[g] = {stall, alu, imm, we, ma, mw, mr, jal, isel, og, br, jmp, f3, rd, exv, ill};
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
      end
   endtask

   // Reference decode from the ISA tables: returns {alu,imm,flags,f3,rd,exv=1,ill=0}.
   function automatic logic [26:0] model_dec(input logic [31:0] ins, input int k,
                                             output int ncyc, output bit legal);
      logic [4:0] alu;
      logic [2:0] imm, f3;
      logic [6:0] f7;
      logic we, ma, mw, mr, jal, isel, og, br, jmp;
      int base [8];
      base = '{0, 2, 3, 4, 5, 6, 8, 9};
      f3 = ins[14:12];
      f7 = ins[31:25];
      alu = 0; imm = 3'b111; ncyc = 1; legal = 1;
      {we, ma, mw, mr, jal, isel, og, br, jmp} = '0;
      case (ins[6:0])
         7'h33: begin
            we = 1;
            if (f7 == 7'h00) alu = 5'(base[f3]);
            else if (f7 == 7'h20 && f3 == 0) alu = 1;
            else if (f7 == 7'h20 && f3 == 5) alu = 7;
            else if (f7 == 7'h01 && k == 0) begin
               alu  = 5'(10 + f3);
               ncyc = (f3 < 4) ? 3 : 4;
            end else legal = 0;
         end
         7'h13: begin
            isel = 1; imm = 0; alu = 5'(base[f3]);
            if (f3 == 1 && f7 != 0) legal = 0;
            if (f3 == 5 && f7 == 7'h20) alu = 7;
            else if (f3 == 5 && f7 != 0) legal = 0;
         end
         7'h03: begin ma = 1; mr = 1; we = 1; imm = 0; legal = (f3 inside {0, 1, 2, 4, 5}); end
         7'h23: begin ma = 1; mw = 1; imm = 1; legal = (f3 < 3); end
         7'h63: begin br = 1; og = 1; alu = 1; imm = 2; legal = !(f3 inside {2, 3}); end
         7'h6F: begin jmp = 1; jal = 1; og = 1; imm = 4; end
         7'h67: begin jmp = 1; jal = 1; isel = 1; imm = 0; legal = (f3 == 0); end
         7'h37: begin alu = 18; imm = 3; end
         7'h17: begin og = 1; imm = 3; end
         default: legal = 0;
      endcase
      return {alu, imm, we, ma, mw, mr, jal, isel, og, br, jmp, f3, ins[11:7], 1'b1, 1'b0};
   endfunction

   function automatic logic exp_stall(input int k);
      int  n;
      bit  legal;
      logic [26:0] d;
      d = model_dec(INSTRUCTION, k, n, legal);
      return (m_wait[k] > 0) || (ID_VALID && legal && n > 1 && d[1]);
   endfunction

   task automatic model_edge(input int k);
      int  n;
      bit  legal;
      logic [26:0] d;
      if (FLUSH) begin
         m_reg[k] = NOP_VEC; m_wait[k] = 0;
      end else if (!HOLD) begin
         if (m_wait[k] > 0) begin
            m_reg[k] = NOP_VEC; m_wait[k]--;
         end else if (!ID_VALID) begin
            m_reg[k] = NOP_VEC;
         end else begin
            d = model_dec(INSTRUCTION, k, n, legal);
            if (!legal) m_reg[k] = NOP_VEC | 27'd1;
            else begin m_reg[k] = d; m_wait[k] = n - 1; end
         end
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin m_reg[k] = NOP_VEC; m_wait[k] = 0; end
   endtask

   task automatic compare_all();
      check_val("ctl0", 32'(obs[0]), 32'({exp_stall(0), m_reg[0]}));
      check_val("ctl1", 32'(obs[1]), 32'({exp_stall(1), m_reg[1]}));
   endtask

   task automatic step(input logic [31:0] ins, input logic v, input logic h, input logic f);
      @(negedge CLK);
      INSTRUCTION = ins; ID_VALID = v; HOLD = h; FLUSH = f;
      #1;
      compare_all();
      if (obs[0][27]) stall_cnt++;
      @(posedge CLK);
      model_edge(0);
      model_edge(1);
   endtask

   function automatic logic [31:0] rand_instr();
      logic [31:0] w;
      w = $urandom;
      case ($urandom_range(0, 12))
         0:  w[6:0] = 7'h33;
         1:  w[6:0] = 7'h13;
         2:  w[6:0] = 7'h03;
         3:  w[6:0] = 7'h23;
         4:  w[6:0] = 7'h63;
         5:  w[6:0] = 7'h6F;
         6:  w[6:0] = 7'h67;
         7:  w[6:0] = 7'h37;
         8:  w[6:0] = 7'h17;
         9:  begin w[6:0] = 7'h33; w[31:25] = 7'h01; end
         10: begin w[6:0] = 7'h33; w[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00; end
         11: begin w[6:0] = 7'h13; w[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00; end
         default: ;
      endcase
      return w;
   endfunction

   initial begin
      model_reset();
      #12;
      compare_all();
      check_val("rst_vec", 32'(obs[0]), 32'({1'b0, NOP_VEC}));
      @(negedge CLK);
      RESET_N = 1'b1;

      step(I_ADD, 1, 0, 0);
      step(I_LW, 1, 0, 0);
      step(I_BEQ, 1, 0, 0);
      step(I_ADDI, 1, 0, 0);

      stall_cnt = 0;
      step(I_DIV, 1, 0, 0);
      for (int i = 0; i < 4; i++) step(I_ADDI, 1, 0, 0);
      check_val("div_stall", stall_cnt, 4);

      step(I_DIV, 1, 0, 0);
      step(I_ADDI, 1, 0, 0);
      step(I_ADDI, 1, 0, 1);
      step(I_ADDI, 1, 0, 0);
      step(I_DIV, 1, 0, 0);
      step(I_ADDI, 1, 1, 1);
      step(I_ADDI, 1, 0, 0);

      step(I_ADD, 1, 0, 0);
      for (int i = 0; i < 3; i++) step(I_LW, 1, 1, 0);
      step(I_LW, 1, 0, 0);

      step(I_DIV, 1, 0, 0);
      step(I_ADDI, 1, 0, 0);
      @(negedge CLK);
      ID_VALID = 1'b0; HOLD = 1'b0; FLUSH = 1'b0;
      RESET_N  = 1'b0;
      #1;
      check_val("rst_async", 32'(obs[0]), 32'({1'b0, NOP_VEC}));
      model_reset();
      #2;
      RESET_N = 1'b1;

      step(32'hFFFFFFFF, 1, 0, 0);
      step(I_ADD, 1, 0, 0);
      step(I_ADD, 0, 0, 0);

      for (int i = 0; i < 600; i++)
         step(rand_instr(), $urandom_range(0, 9) != 0,
              $urandom_range(0, 6) == 0, $urandom_range(0, 11) == 0);
      step(I_ADDI, 1, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
